piarb_queue_ctl: RTL and testbench

//  Per-PU descriptor queue controller; sits directly upstream of the PU scheduler.
//  - Stores enqueued descriptors in QUEUE_DEPTH circular queues held in one shared RAM.
//  - Tracks per-queue depth and returns enqueue acks (with to-empty flag) and dequeue acks
//    (with emptyp2 flag); the scheduler uses these flags to keep its eligible-qid list.
//  - Serves dequeue requests issued by the scheduler and returns the descriptor.

---
 rtl/piarb_queue_ctl.sv | 174 +++++++++++++++++
 tb/tb_piarb_queue_ctl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/piarb_queue_ctl.sv
// Per-PU descriptor queue controller: QUEUE_DEPTH circular queues held in one shared RAM,
// with registered enqueue/dequeue acks. Define PIARB_QUEUE_CTL_CNT_EN to add drop/error counters.
module piarb_queue_ctl #(
  parameter int QUEUE_ID_NBITS      = 5,
  parameter int QUEUE_DEPTH         = 32,
  parameter int QUEUE_ENTRIES_NBITS = 2,
  parameter int QUEUE_PAYLOAD_NBITS = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           enq_req,
  input  logic [QUEUE_ID_NBITS-1:0]      enq_qid,
  input  logic [QUEUE_PAYLOAD_NBITS-1:0] enq_desc,
  output logic                           enq_ack,
  output logic                           enq_to_empty,
  output logic [QUEUE_ID_NBITS-1:0]      enq_ack_qid,
  output logic                           enq_drop,
  input  logic                           deq_req,
  input  logic [QUEUE_ID_NBITS-1:0]      deq_qid,
  output logic                           deq_depth_ack,
  output logic                           deq_depth_from_emptyp2,
  output logic [QUEUE_ID_NBITS-1:0]      deq_ack_qid,
  output logic [QUEUE_PAYLOAD_NBITS-1:0] deq_desc,
  output logic                           deq_err
`ifdef PIARB_QUEUE_CTL_CNT_EN
  ,
  output logic [15:0]                    drop_cnt,
  output logic [15:0]                    deq_err_cnt
`endif
);

  localparam int NE      = QUEUE_ENTRIES_NBITS;
  localparam int ENTRIES = 1 << NE;
  localparam int AW      = QUEUE_ID_NBITS + NE;

  typedef logic [NE:0]                    depth_t;
  typedef logic [NE-1:0]                  ptr_t;
  typedef logic [QUEUE_ID_NBITS-1:0]      qid_t;
  typedef logic [QUEUE_PAYLOAD_NBITS-1:0] payload_t;

  localparam depth_t FULL_DEPTH = ENTRIES[NE:0];

  depth_t   depth_q  [QUEUE_DEPTH];
  depth_t   depth_d  [QUEUE_DEPTH];
  ptr_t     wr_ptr_q [QUEUE_DEPTH];
  ptr_t     wr_ptr_d [QUEUE_DEPTH];
  ptr_t     rd_ptr_q [QUEUE_DEPTH];
  ptr_t     rd_ptr_d [QUEUE_DEPTH];
  payload_t mem      [QUEUE_DEPTH*ENTRIES];

  depth_t   enq_cur_depth, deq_cur_depth;
  logic     enq_ok, deq_ok, same_q;
  logic [AW-1:0] wr_addr, rd_addr;

  logic     enq_ack_q, enq_ack_d;
  logic     enq_to_empty_q, enq_to_empty_d;
  qid_t     enq_ack_qid_q, enq_ack_qid_d;
  logic     enq_drop_q, enq_drop_d;
  logic     deq_ack_q, deq_ack_d;
  logic     emptyp2_q, emptyp2_d;
  qid_t     deq_ack_qid_q, deq_ack_qid_d;
  payload_t deq_desc_q, deq_desc_d;
  logic     deq_err_q, deq_err_d;

  // Both ops see the depth from before this cycle; full/empty decisions never chain.
  assign enq_cur_depth = depth_q[enq_qid];
  assign deq_cur_depth = depth_q[deq_qid];
  assign enq_ok        = enq_req && (enq_cur_depth != FULL_DEPTH);
  assign deq_ok        = deq_req && (deq_cur_depth != '0);
  assign same_q        = (enq_qid == deq_qid);
  assign wr_addr       = {enq_qid, wr_ptr_q[enq_qid]};
  assign rd_addr       = {deq_qid, rd_ptr_q[deq_qid]};

  always_comb begin
    depth_d  = depth_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    // NOTE: blocking updates here accumulate, so a same-qid enq+deq nets to no depth change.
    if (enq_ok) begin
      wr_ptr_d[enq_qid] = wr_ptr_q[enq_qid] + ptr_t'(1);
      depth_d[enq_qid]  = depth_d[enq_qid] + depth_t'(1);
    end
    if (deq_ok) begin
      rd_ptr_d[deq_qid] = rd_ptr_q[deq_qid] + ptr_t'(1);
      depth_d[deq_qid]  = depth_d[deq_qid] - depth_t'(1);
    end
  end

  always_comb begin
    enq_ack_d      = enq_ok;
    enq_drop_d     = enq_req && !enq_ok;
    enq_to_empty_d = enq_ok && (enq_cur_depth == '0);
    enq_ack_qid_d  = enq_req ? enq_qid : '0;
    deq_ack_d      = deq_req;
    deq_err_d      = deq_req && !deq_ok;
    // A same-cycle enqueue to a queue holding one entry keeps it eligible after this dequeue.
    emptyp2_d      = deq_ok && ((deq_cur_depth > depth_t'(1)) ||
                                (same_q && enq_ok));
    deq_ack_qid_d  = deq_req ? deq_qid : '0;
    deq_desc_d     = deq_ok ? mem[rd_addr] : '0;
  end

  // NOTE: the descriptor RAM has no reset; depth counters alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (enq_ok) mem[wr_addr] <= enq_desc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth_q        <= '{default: '0};
      wr_ptr_q       <= '{default: '0};
      rd_ptr_q       <= '{default: '0};
      enq_ack_q      <= 1'b0;
      enq_to_empty_q <= 1'b0;
      enq_ack_qid_q  <= '0;
      enq_drop_q     <= 1'b0;
      deq_ack_q      <= 1'b0;
      emptyp2_q      <= 1'b0;
      deq_ack_qid_q  <= '0;
      deq_desc_q     <= '0;
      deq_err_q      <= 1'b0;
    end else begin
      depth_q        <= depth_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      enq_ack_q      <= enq_ack_d;
      enq_to_empty_q <= enq_to_empty_d;
      enq_ack_qid_q  <= enq_ack_qid_d;
      enq_drop_q     <= enq_drop_d;
      deq_ack_q      <= deq_ack_d;
      emptyp2_q      <= emptyp2_d;
      deq_ack_qid_q  <= deq_ack_qid_d;
      deq_desc_q     <= deq_desc_d;
      deq_err_q      <= deq_err_d;
    end
  end

  assign enq_ack                = enq_ack_q;
  assign enq_to_empty           = enq_to_empty_q;
  assign enq_ack_qid            = enq_ack_qid_q;
  assign enq_drop               = enq_drop_q;
  assign deq_depth_ack          = deq_ack_q;
  assign deq_depth_from_emptyp2 = emptyp2_q;
  assign deq_ack_qid            = deq_ack_qid_q;
  assign deq_desc               = deq_desc_q;
  assign deq_err                = deq_err_q;

`ifdef PIARB_QUEUE_CTL_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic [15:0] deq_err_cnt_q, deq_err_cnt_d;

  // Counters advance together with the pulse they count and stick at all-ones.
  always_comb begin
    drop_cnt_d    = drop_cnt_q;
    deq_err_cnt_d = deq_err_cnt_q;
    if (enq_drop_d && (drop_cnt_q != 16'hFFFF))   drop_cnt_d    = drop_cnt_q + 16'd1;
    if (deq_err_d && (deq_err_cnt_q != 16'hFFFF)) deq_err_cnt_d = deq_err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q    <= '0;
      deq_err_cnt_q <= '0;
    end else begin
      drop_cnt_q    <= drop_cnt_d;
      deq_err_cnt_q <= deq_err_cnt_d;
    end
  end

  assign drop_cnt    = drop_cnt_q;
  assign deq_err_cnt = deq_err_cnt_q;
`endif

endmodule

// File: tb/tb_piarb_queue_ctl.sv
// Self-checking bench for piarb_queue_ctl (default parameters: 32 queues x 4 entries, 16-bit descriptors).
module tb_piarb_queue_ctl;

  localparam int QW = 5;
  localparam int PW = 16;
  localparam int E  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enq_req = 1'b0;
  logic [QW-1:0] enq_qid = '0;
  logic [PW-1:0] enq_desc = '0;
  logic          enq_ack, enq_to_empty, enq_drop;
  logic [QW-1:0] enq_ack_qid;
  logic          deq_req = 1'b0;
  logic [QW-1:0] deq_qid = '0;
  logic          deq_depth_ack, deq_depth_from_emptyp2, deq_err;
  logic [QW-1:0] deq_ack_qid;
  logic [PW-1:0] deq_desc;
`ifdef PIARB_QUEUE_CTL_CNT_EN
  logic [15:0]   drop_cnt, deq_err_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  piarb_queue_ctl dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .enq_req                (enq_req),
    .enq_qid                (enq_qid),
    .enq_desc               (enq_desc),
    .enq_ack                (enq_ack),
    .enq_to_empty           (enq_to_empty),
    .enq_ack_qid            (enq_ack_qid),
    .enq_drop               (enq_drop),
    .deq_req                (deq_req),
    .deq_qid                (deq_qid),
    .deq_depth_ack          (deq_depth_ack),
    .deq_depth_from_emptyp2 (deq_depth_from_emptyp2),
    .deq_ack_qid            (deq_ack_qid),
    .deq_desc               (deq_desc),
    .deq_err                (deq_err)
`ifdef PIARB_QUEUE_CTL_CNT_EN
    ,
    .drop_cnt               (drop_cnt),
    .deq_err_cnt            (deq_err_cnt)
`endif
  );

  typedef struct {
    logic          enq;
    logic [QW-1:0] eq;
    logic [PW-1:0] ed;
    logic          deq;
    logic [QW-1:0] dq;
    logic          x_eack;
    logic          x_empty;
    logic          x_drop;
    logic          x_dack;
    logic          x_p2;
    logic          x_err;
    logic [PW-1:0] x_desc;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one request cycle from a negedge and checks the registered response 1 ns after the edge.
  task automatic step(input string tag, input vec_t v);
    enq_req = v.enq; enq_qid = v.eq; enq_desc = v.ed;
    deq_req = v.deq; deq_qid = v.dq;
    @(posedge clk); #1;
    check({tag, ".enq_ack"}, 32'(enq_ack), 32'(v.x_eack));
    check({tag, ".enq_drop"}, 32'(enq_drop), 32'(v.x_drop));
    check({tag, ".deq_ack"}, 32'(deq_depth_ack), 32'(v.x_dack));
    check({tag, ".deq_err"}, 32'(deq_err), 32'(v.x_err));
    if (v.x_eack) begin
      check({tag, ".to_empty"}, 32'(enq_to_empty), 32'(v.x_empty));
      check({tag, ".enq_qid"}, 32'(enq_ack_qid), 32'(v.eq));
    end
    if (v.x_dack) begin
      check({tag, ".emptyp2"}, 32'(deq_depth_from_emptyp2), 32'(v.x_p2));
      check({tag, ".deq_qid"}, 32'(deq_ack_qid), 32'(v.dq));
      if (!v.x_err) check({tag, ".deq_desc"}, 32'(deq_desc), 32'(v.x_desc));
    end
    @(negedge clk);
    enq_req = 1'b0; deq_req = 1'b0;
  endtask

  function automatic vec_t mk(input logic enq, input int eq, input int ed,
                              input logic deq, input int dq,
                              input logic eack, input logic emp, input logic drop,
                              input logic dack, input logic p2, input logic err, input int desc);
    vec_t v;
    v.enq = enq; v.eq = QW'(eq); v.ed = PW'(ed); v.deq = deq; v.dq = QW'(dq);
    v.x_eack = eack; v.x_empty = emp; v.x_drop = drop;
    v.x_dack = dack; v.x_p2 = p2; v.x_err = err; v.x_desc = PW'(desc);
    return v;
  endfunction

  vec_t tbl [15];
  logic [PW-1:0] model_q [$];

  initial begin
    //        enq eq  ed      deq dq  eack emp drop dack p2  err desc
    tbl[0]  = mk(1, 3, 'hA001, 0, 0,   1,  1,  0,   0,   0,  0,  0);
    tbl[1]  = mk(1, 3, 'hB002, 0, 0,   1,  0,  0,   0,   0,  0,  0);
    tbl[2]  = mk(1, 5, 'h005A, 0, 0,   1,  1,  0,   0,   0,  0,  0);
    tbl[3]  = mk(1, 5, 'h005B, 0, 0,   1,  0,  0,   0,   0,  0,  0);
    tbl[4]  = mk(0, 0, 0,      1, 5,   0,  0,  0,   1,   1,  0,  'h005A);
    tbl[5]  = mk(0, 0, 0,      1, 5,   0,  0,  0,   1,   0,  0,  'h005B);
    tbl[6]  = mk(0, 0, 0,      1, 2,   0,  0,  0,   1,   0,  1,  0);
    tbl[7]  = mk(1, 9, 'h0900, 0, 0,   1,  1,  0,   0,   0,  0,  0);
    tbl[8]  = mk(1, 9, 'h0901, 1, 9,   1,  0,  0,   1,   1,  0,  'h0900);
    tbl[9]  = mk(0, 0, 0,      1, 9,   0,  0,  0,   1,   0,  0,  'h0901);
    tbl[10] = mk(0, 0, 0,      1, 9,   0,  0,  0,   1,   0,  1,  0);
    tbl[11] = mk(1, 4, 'h0400, 1, 3,   1,  1,  0,   1,   1,  0,  'hA001);
    tbl[12] = mk(0, 0, 0,      1, 3,   0,  0,  0,   1,   0,  0,  'hB002);
    tbl[13] = mk(1, 6, 'h0600, 1, 6,   1,  1,  0,   1,   0,  1,  0);
    tbl[14] = mk(0, 0, 0,      1, 6,   0,  0,  0,   1,   0,  0,  'h0600);

    repeat (2) @(negedge clk);
    check("reset.enq_ack", 32'(enq_ack), 32'd0);
    check("reset.enq_drop", 32'(enq_drop), 32'd0);
    check("reset.deq_ack", 32'(deq_depth_ack), 32'd0);
    check("reset.deq_desc", 32'(deq_desc), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 15; i++) step($sformatf("vec%0d", i), tbl[i]);

`ifdef PIARB_QUEUE_CTL_CNT_EN
    // Deq errors so far: q2, q9, q6.
    check("cnt.deq_err_cnt", 32'(deq_err_cnt), 32'd3);
`endif

    // Fill q7, overflow it, then stream enq+deq so both pointers wrap twice.
    for (int i = 0; i < E; i++) begin
      step($sformatf("fill%0d", i), mk(1, 7, 'h0700 + i, 0, 0, 1, i == 0, 0, 0, 0, 0, 0));
      model_q.push_back(PW'('h0700 + i));
    end
    step("full_drop", mk(1, 7, 'h07EE, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    step("full_enq_deq", mk(1, 7, 'h07FF, 1, 7, 0, 0, 1, 1, 1, 0, 'h0700));
    void'(model_q.pop_front());
    for (int i = 0; i < 2 * E; i++) begin
      int d;
      logic [PW-1:0] exp_desc;
      d = model_q.size();
      exp_desc = model_q.pop_front();
      model_q.push_back(PW'('h0710 + i));
      step($sformatf("wrap%0d", i),
           mk(1, 7, 'h0710 + i, 1, 7, 1, d == 0, 0, 1, d + 1 >= 2, 0, int'(exp_desc)));
    end
    while (model_q.size() > 0) begin
      int d;
      logic [PW-1:0] exp_desc;
      d = model_q.size();
      exp_desc = model_q.pop_front();
      step($sformatf("drain%0d", d), mk(0, 0, 0, 1, 7, 0, 0, 0, 1, d >= 2, 0, int'(exp_desc)));
    end
    step("drain_empty", mk(0, 0, 0, 1, 7, 0, 0, 0, 1, 0, 1, 0));

`ifdef PIARB_QUEUE_CTL_CNT_EN
    check("cnt.drop_cnt", 32'(drop_cnt), 32'd2);
`endif

    // Reset lands between request and ack: nothing is acked and every queue reads empty.
    step("pre_rst_enq", mk(1, 11, 'h0B00, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    enq_req = 1'b1; enq_qid = 5'd10; enq_desc = 16'h0A00;
    deq_req = 1'b1; deq_qid = 5'd11;
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst.enq_ack", 32'(enq_ack), 32'd0);
    check("rst.deq_ack", 32'(deq_depth_ack), 32'd0);
    @(negedge clk);
    enq_req = 1'b0; deq_req = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    step("post_rst_q11", mk(0, 0, 0, 1, 11, 0, 0, 0, 1, 0, 1, 0));
    step("post_rst_q10", mk(0, 0, 0, 1, 10, 0, 0, 0, 1, 0, 1, 0));
    step("post_rst_q4",  mk(0, 0, 0, 1, 4,  0, 0, 0, 1, 0, 1, 0));
    step("post_rst_enq", mk(1, 4, 'h0444, 0, 0, 1, 1, 0, 0, 0, 0, 0));
`ifdef PIARB_QUEUE_CTL_CNT_EN
    check("cnt.after_rst", 32'(deq_err_cnt), 32'd3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
